mem_crossbar_n: RTL and testbench

Parametrised N-target successor to the two-way mem/MMIO crossbar between the MMU data port and the Dcache/MMIO paths. It decodes the physical address against per-slave base/mask regions and forwards the request to exactly one slave. It holds the chosen target for the whole stalled transaction, and returns read data and stall from that target only. It adds what the two-way version lacks: unmapped-address faults and a per-transaction stall timeout, both reported as a one-cycle error completion.

---
 rtl/crossbar_pkg.sv | 18 +
 rtl/addr_decoder_n.sv | 26 ++
 rtl/mem_crossbar_n.sv | 158 +++++++++++++++
 tb/tb_mem_crossbar_n.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// Shared types and constants for the N-target memory/MMIO crossbar.
package crossbar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } xbar_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  localparam logic [63:0] MEM_BASE       = 64'h0000_0000_0000_0000;
  localparam logic [63:0] MMIO_BASE      = 64'h0000_0000_8000_0000;
  localparam logic [63:0] REGION_MASK_2G = 64'hFFFF_FFFF_8000_0000;

endpackage

// File: rtl/addr_decoder_n.sv
// Base/mask address decoder with lowest-index-wins priority on overlaps.
module addr_decoder_n #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int IDX_W      = 1,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit_any,
  output logic [IDX_W-1:0]      idx
);

  // Scan from the highest slave down so the lowest matching index is the last one written.
  always_comb begin
    hit_any = 1'b0;
    idx     = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit_any = 1'b1;
        idx     = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_crossbar_n.sv
// N-target crossbar between the MMU data port and downstream slaves, with
// sticky routing during stalls, unmapped-address faults and a stall timeout.
module mem_crossbar_n
  import crossbar_pkg::*;
#(
  parameter int NUM_SLAVES     = 2,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_BASE = {MEM_BASE, MMIO_BASE},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_MASK = {REGION_MASK_2G, REGION_MASK_2G},
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wen_cpu,
  input  logic                             ren_cpu,
  input  logic [ADDR_WIDTH-1:0]            address_cpu,
  output logic [DATA_WIDTH-1:0]            rdata_cpu,
  output logic                             mem_stall,
  output logic [NUM_SLAVES-1:0]            wen_slv,
  output logic [NUM_SLAVES-1:0]            ren_slv,
  input  logic [NUM_SLAVES-1:0]            stall_slv,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] rdata_slv,
  output logic                             err_valid,
  output logic [1:0]                       err_code,
  output logic [ADDR_WIDTH-1:0]            err_addr
);

  localparam int TGT_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  xbar_state_t            state, next_state;
  logic [TGT_W-1:0]       tgt;
  logic [CNT_W-1:0]       cnt;
  logic                   req;
  logic                   hit_any;
  logic [TGT_W-1:0]       dec_idx;
  logic                   timeout_hit;
  logic                   fwd;
  logic [TGT_W-1:0]       sel;
  logic [DATA_WIDTH-1:0]  rdata_arr [NUM_SLAVES];

  assign req = wen_cpu | ren_cpu;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_unpack
    assign rdata_arr[g] = rdata_slv[g*DATA_WIDTH +: DATA_WIDTH];
  end

  addr_decoder_n #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (TGT_W),
    .REGION_BASE(REGION_BASE),
    .REGION_MASK(REGION_MASK)
  ) u_dec (
    .addr   (address_cpu),
    .hit_any(hit_any),
    .idx    (dec_idx)
  );

  // A stalled transaction is abandoned once it has spent TIMEOUT_CYCLES cycles in BUSY.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == BUSY) && req &&
                       stall_slv[tgt] && (cnt == CNT_MAX);

  // State, latched target, stall counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tgt      <= '0;
      cnt      <= '0;
      err_code <= ERR_NONE;
      err_addr <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req && hit_any && stall_slv[dec_idx]) begin
            tgt <= dec_idx;
            cnt <= CNT_W'(1);
          end else if (req && !hit_any) begin
            err_code <= ERR_UNMAPPED;
            err_addr <= address_cpu;
          end
        end
        BUSY: begin
          if (timeout_hit) begin
            err_code <= ERR_TIMEOUT;
            err_addr <= address_cpu;
          end else if (next_state == BUSY) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic: stall holds us in BUSY, faults pass through a single ERR cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (!hit_any)                next_state = ERR;
          else if (stall_slv[dec_idx]) next_state = BUSY;
        end
      end
      BUSY: begin
        if (!req || !stall_slv[tgt]) next_state = IDLE;
        else if (timeout_hit)        next_state = ERR;
      end
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output muxing: route to one slave only, everything forced quiet while in reset.
  always_comb begin
    fwd       = 1'b0;
    sel       = '0;
    wen_slv   = '0;
    ren_slv   = '0;
    mem_stall = 1'b0;
    rdata_cpu = '0;
    err_valid = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit_any) begin
              fwd       = 1'b1;
              sel       = dec_idx;
              mem_stall = stall_slv[dec_idx];
            end else begin
              mem_stall = 1'b1;
            end
          end
        end
        BUSY: begin
          if (req) begin
            sel       = tgt;
            mem_stall = stall_slv[tgt];
            fwd       = !timeout_hit;
          end
        end
        ERR:     err_valid = 1'b1;
        default: ;
      endcase
      if (fwd) begin
        wen_slv[sel] = wen_cpu;
        ren_slv[sel] = ren_cpu & ~wen_cpu;
        rdata_cpu    = rdata_arr[sel];
      end
    end
  end

endmodule

// File: tb/tb_mem_crossbar_n.sv
// Directed bench: default two-slave crossbar plus a three-slave, short-timeout instance.
module tb_mem_crossbar_n;
  import crossbar_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         wen_a = 0, ren_a = 0;
  logic [63:0]  addr_a = '0;
  logic [63:0]  rdata_cpu_a;
  logic         mem_stall_a;
  logic [1:0]   wen_slv_a, ren_slv_a;
  logic [1:0]   stall_slv_a = '0;
  logic [127:0] rdata_slv_a = {64'h0000_0000_0000_1111, 64'h0000_0000_DEAD_BEEF};
  logic         err_valid_a;
  logic [1:0]   err_code_a;
  logic [63:0]  err_addr_a;

  logic         wen_b = 0, ren_b = 0;
  logic [63:0]  addr_b = '0;
  logic [63:0]  rdata_cpu_b;
  logic         mem_stall_b;
  logic [2:0]   wen_slv_b, ren_slv_b;
  logic [2:0]   stall_slv_b = '0;
  logic [191:0] rdata_slv_b = {64'h2222, 64'h1111, 64'h0AAA};
  logic         err_valid_b;
  logic [1:0]   err_code_b;
  logic [63:0]  err_addr_b;

  int pass_count  = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  mem_crossbar_n dut_a (
    .clk(clk), .rst(rst), .wen_cpu(wen_a), .ren_cpu(ren_a), .address_cpu(addr_a),
    .rdata_cpu(rdata_cpu_a), .mem_stall(mem_stall_a), .wen_slv(wen_slv_a), .ren_slv(ren_slv_a),
    .stall_slv(stall_slv_a), .rdata_slv(rdata_slv_a), .err_valid(err_valid_a),
    .err_code(err_code_a), .err_addr(err_addr_a)
  );

  mem_crossbar_n #(
    .NUM_SLAVES(3),
    .REGION_BASE({64'h0000_0001_0000_0000, MEM_BASE, MMIO_BASE}),
    .REGION_MASK({64'hFFFF_FFFF_0000_0000, REGION_MASK_2G, REGION_MASK_2G}),
    .TIMEOUT_CYCLES(4)
  ) dut_b (
    .clk(clk), .rst(rst), .wen_cpu(wen_b), .ren_cpu(ren_b), .address_cpu(addr_b),
    .rdata_cpu(rdata_cpu_b), .mem_stall(mem_stall_b), .wen_slv(wen_slv_b), .ren_slv(ren_slv_b),
    .stall_slv(stall_slv_b), .rdata_slv(rdata_slv_b), .err_valid(err_valid_b),
    .err_code(err_code_b), .err_addr(err_addr_b)
  );

  // Advance to just after the next rising edge so inputs change away from it.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic [63:0] a, input logic [1:0] st);
    wen_a = w; ren_a = r; addr_a = a; stall_slv_a = st;
    #1;
  endtask

  task automatic applyStimulusB(input logic w, input logic r, input logic [63:0] a, input logic [2:0] st);
    wen_b = w; ren_b = r; addr_b = a; stall_slv_b = st;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    // Reset state
    applyStimulus(0, 0, 64'h0, 2'b00);
    applyStimulusB(0, 0, 64'h0, 3'b000);
    nextCycle();
    nextCycle();
    checkOutput("rst_stall", mem_stall_a, 0);
    checkOutput("rst_en", {wen_slv_a, ren_slv_a}, 0);
    checkOutput("rst_code", err_code_a, 0);
    checkOutput("rst_addr", err_addr_a, 0);
    rst = 1'b0;
    nextCycle();

    // Zero-latency read to slave0 (MMIO region)
    applyStimulus(0, 1, 64'h8000_0100, 2'b00);
    checkOutput("rd_ren", ren_slv_a, 2'b01);
    checkOutput("rd_wen", wen_slv_a, 2'b00);
    checkOutput("rd_stall", mem_stall_a, 0);
    checkOutput("rd_data", rdata_cpu_a, 64'hDEAD_BEEF);
    nextCycle();
    applyStimulus(0, 0, 64'h8000_0100, 2'b00);
    checkOutput("idle_ren", ren_slv_a, 2'b00);
    checkOutput("idle_data", rdata_cpu_a, 0);
    nextCycle();
    applyStimulus(0, 1, 64'h8000_0200, 2'b00);
    checkOutput("rd2_ren", ren_slv_a, 2'b01);
    checkOutput("rd2_stall", mem_stall_a, 0);
    nextCycle();

    // Write to slave1 stalled 5 cycles; address moves to slave0 region mid-stall
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 0, (k >= 3) ? 64'h8000_0000 : 64'h1000_0000, (k < 5) ? 2'b10 : 2'b00);
      checkOutput($sformatf("wr_wen_%0d", k), wen_slv_a, 2'b10);
      checkOutput($sformatf("wr_stall_%0d", k), mem_stall_a, (k < 5) ? 1 : 0);
      checkOutput($sformatf("wr_err_%0d", k), err_valid_a, 0);
      nextCycle();
    end
    applyStimulus(0, 0, 64'h0, 2'b00);
    checkOutput("wr_done_wen", wen_slv_a, 2'b00);

    // Unmapped address on the default instance to leave a sticky error code
    applyStimulus(0, 1, 64'h2_0000_0000, 2'b00);
    checkOutput("a_unm_stall", mem_stall_a, 1);
    nextCycle();
    applyStimulus(0, 0, 64'h0, 2'b00);
    checkOutput("a_unm_valid", err_valid_a, 1);
    checkOutput("a_unm_code", err_code_a, 2'b01);
    nextCycle();

    // Flush: read drops on the 3rd stall cycle
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 1, 64'h8000_0100, 2'b01);
      checkOutput($sformatf("fl_ren_%0d", k), ren_slv_a, 2'b01);
      checkOutput($sformatf("fl_stall_%0d", k), mem_stall_a, 1);
      nextCycle();
    end
    applyStimulus(0, 0, 64'h8000_0100, 2'b01);
    checkOutput("fl_drop_en", ren_slv_a, 2'b00);
    checkOutput("fl_drop_stall", mem_stall_a, 0);
    checkOutput("fl_drop_err", err_valid_a, 0);
    nextCycle();
    checkOutput("fl_after_err", err_valid_a, 0);
    checkOutput("fl_after_stall", mem_stall_a, 0);
    applyStimulus(0, 0, 64'h0, 2'b00);
    nextCycle();

    // Reset in the middle of a stalled read
    applyStimulus(0, 1, 64'h8000_0100, 2'b01);
    nextCycle();
    checkOutput("rb_busy_ren", ren_slv_a, 2'b01);
    rst = 1'b1;
    #1;
    checkOutput("rb_rst_ren", ren_slv_a, 2'b00);
    checkOutput("rb_rst_stall", mem_stall_a, 0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 0, 64'h0, 2'b00);
    checkOutput("rb_after_en", {wen_slv_a, ren_slv_a}, 0);
    checkOutput("rb_after_stall", mem_stall_a, 0);
    checkOutput("rb_after_code", err_code_a, 0);
    checkOutput("rb_after_addr", err_addr_a, 0);
    checkOutput("rb_after_data", rdata_cpu_a, 0);
    nextCycle();

    // Simultaneous write and read is a write
    applyStimulus(1, 1, 64'h8000_0000, 2'b00);
    checkOutput("wr_rd_wen", wen_slv_a, 2'b01);
    checkOutput("wr_rd_ren", ren_slv_a, 2'b00);
    nextCycle();
    applyStimulus(0, 0, 64'h0, 2'b00);

    // Three-slave instance: third region decodes
    applyStimulusB(0, 1, 64'h1_0000_0040, 3'b000);
    checkOutput("b_s2_ren", ren_slv_b, 3'b100);
    checkOutput("b_s2_data", rdata_cpu_b, 64'h2222);
    nextCycle();

    // Unmapped read: one stall cycle, then error completion (request held into ERR)
    applyStimulusB(0, 1, 64'h2_0000_0000, 3'b000);
    checkOutput("b_unm_stall", mem_stall_b, 1);
    checkOutput("b_unm_en", {wen_slv_b, ren_slv_b}, 0);
    checkOutput("b_unm_data", rdata_cpu_b, 0);
    checkOutput("b_unm_v0", err_valid_b, 0);
    nextCycle();
    checkOutput("b_err_valid", err_valid_b, 1);
    checkOutput("b_err_code", err_code_b, 2'b01);
    checkOutput("b_err_addr", err_addr_b, 64'h2_0000_0000);
    checkOutput("b_err_stall", mem_stall_b, 0);
    checkOutput("b_err_data", rdata_cpu_b, 0);
    checkOutput("b_err_en", {wen_slv_b, ren_slv_b}, 0);
    applyStimulusB(0, 0, 64'h0, 3'b000);
    nextCycle();
    checkOutput("b_err_clear", err_valid_b, 0);
    checkOutput("b_err_hold", err_code_b, 2'b01);

    // Timeout: slave0 stall stuck, four BUSY cycles then ERR
    for (int k = 0; k < 5; k++) begin
      applyStimulusB(0, 1, 64'h8000_0000, 3'b001);
      checkOutput($sformatf("to_ren_%0d", k), ren_slv_b, (k < 4) ? 3'b001 : 3'b000);
      checkOutput($sformatf("to_stall_%0d", k), mem_stall_b, 1);
      checkOutput($sformatf("to_v_%0d", k), err_valid_b, 0);
      nextCycle();
    end
    applyStimulusB(0, 0, 64'h0, 3'b001);
    checkOutput("to_err_valid", err_valid_b, 1);
    checkOutput("to_err_code", err_code_b, 2'b10);
    checkOutput("to_err_addr", err_addr_b, 64'h8000_0000);
    checkOutput("to_err_stall", mem_stall_b, 0);
    checkOutput("to_err_en", ren_slv_b, 3'b000);
    nextCycle();
    checkOutput("to_idle_valid", err_valid_b, 0);
    checkOutput("to_idle_stall", mem_stall_b, 0);
    applyStimulusB(0, 1, 64'h1_0000_0040, 3'b000);
    checkOutput("to_idle_ren", ren_slv_b, 3'b100);
    checkOutput("to_idle_rstall", mem_stall_b, 0);
    nextCycle();
    applyStimulusB(0, 0, 64'h0, 3'b000);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
